// File: rtl/imm_encode.sv
// imm_encode: builds instruction words whose immediate field decodes back to a
// requested value. Zero-extended constants that do not fit in a byte expand
// into an LLB/LHB word pair. Values that cannot be represented are emitted as
// a single word with the field cleared and out_err set, and they are counted.
module imm_encode #(
  parameter logic [3:0] LHB_OPCODE = 4'b1011,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [15:0]          in_value,
  input  logic [15:0]          in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_instr,
  output logic                 out_last,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pend_word;

  logic [15:0] word1;
  logic [15:0] word2;
  logic        two_word;
  logic        enc_err;
  logic        accept;
  logic        xfer;

  // Returns 1 when v[15:lsb] are all equal, i.e. v fits as a signed value
  // whose sign bit sits at position lsb.
  function automatic logic sext_fits(input logic [15:0] v, input int lsb);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i >= lsb) begin
        all_one  = all_one & v[i];
        all_zero = all_zero & ~v[i];
      end
    end
    return all_one | all_zero;
  endfunction

  // Combinational field encoding of the incoming request.
  always_comb begin
    word1    = in_base;
    word2    = {LHB_OPCODE, in_base[11:8], in_value[15:8]};
    two_word = 1'b0;
    enc_err  = 1'b0;
    case (in_kind)
      2'b00: begin
        // Branch: 9-bit field scaled by 2, so the value must be even and
        // representable as a 10-bit signed number.
        if (!in_value[0] && sext_fits(in_value, 9)) begin
          word1[8:0] = in_value[9:1];
        end else begin
          word1[8:0] = 9'd0;
          enc_err    = 1'b1;
        end
      end
      2'b01: begin
        // Memory offset: plain 4-bit signed field.
        if (sext_fits(in_value, 3)) begin
          word1[3:0] = in_value[3:0];
        end else begin
          word1[3:0] = 4'd0;
          enc_err    = 1'b1;
        end
      end
      2'b10: begin
        // Immediate: 8-bit field scaled by 2, value must be even and fit in
        // 9 signed bits.
        if (!in_value[0] && sext_fits(in_value, 8)) begin
          word1[7:0] = in_value[8:1];
        end else begin
          word1[7:0] = 8'd0;
          enc_err    = 1'b1;
        end
      end
      default: begin
        // Zero-extended byte; any nonzero high byte needs a following LHB.
        word1[7:0] = in_value[7:0];
        two_word   = |in_value[15:8];
      end
    endcase
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state == EMPTY) || ((state == ONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Output register, pending LHB word and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_instr <= 16'h0000;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      pend_word <= 16'h0000;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_instr <= word1;
        out_last  <= ~two_word;
        out_err   <= enc_err;
        pend_word <= word2;
        state     <= two_word ? TWO : ONE;
        if (enc_err && (err_count != {ERR_CNT_W{1'b1}})) begin
          err_count <= err_count + 1'b1;
        end
      end else if (xfer) begin
        if (state == TWO) begin
          out_instr <= pend_word;
          out_last  <= 1'b1;
          out_err   <= 1'b0;
          state     <= ONE;
        end else begin
          state <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: vector table for single-word encodings plus
// hand-written sequences for pairs, backpressure, streaming and reset.
module tb_imm_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [15:0] in_value;
  logic [15:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        out_last;
  logic        out_err;
  logic [7:0]  err_count;

  int total;
  int bad;
  int exp_errs;

  imm_encode #(.LHB_OPCODE(4'b1011), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_value  (in_value),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] value;
    logic [15:0] base;
    logic [15:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; waits (bounded) for in_ready, then presents a request
  // for exactly one accept edge and returns at accept edge + 1.
  task automatic send(input logic [1:0] kind, input logic [15:0] value, input logic [15:0] base);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_kind  = kind;
    in_value = value;
    in_base  = base;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_errs  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 2'b00;
    in_value  = 16'h0000;
    in_base   = 16'h0000;
    out_ready = 1'b1;

    vecs[0]  = '{2'b00, 16'hFFFE, 16'hC000, 16'hC1FF, 1'b0};
    vecs[1]  = '{2'b01, 16'h0008, 16'h8120, 16'h8120, 1'b1};
    vecs[2]  = '{2'b01, 16'hFFF8, 16'h8120, 16'h8128, 1'b0};
    vecs[3]  = '{2'b10, 16'h0101, 16'h5A3C, 16'h5A00, 1'b1};
    vecs[4]  = '{2'b10, 16'hFF00, 16'h5A3C, 16'h5A80, 1'b0};
    vecs[5]  = '{2'b11, 16'h00AB, 16'hA300, 16'hA3AB, 1'b0};
    vecs[6]  = '{2'b00, 16'h01FE, 16'hC000, 16'hC0FF, 1'b0};
    vecs[7]  = '{2'b00, 16'h0200, 16'hC1FF, 16'hC000, 1'b1};
    vecs[8]  = '{2'b00, 16'hFE00, 16'hC000, 16'hC100, 1'b0};
    vecs[9]  = '{2'b00, 16'h0003, 16'hC000, 16'hC000, 1'b1};
    vecs[10] = '{2'b01, 16'h0007, 16'h0000, 16'h0007, 1'b0};
    vecs[11] = '{2'b10, 16'h00FE, 16'h0000, 16'h007F, 1'b0};
    vecs[12] = '{2'b10, 16'h0100, 16'h00FF, 16'h0000, 1'b1};
    vecs[13] = '{2'b01, 16'hFFF7, 16'hFFFF, 16'hFFF0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven single-word encodings
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].kind, vecs[i].value, vecs[i].base);
      if (vecs[i].exp_err) exp_errs++;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_instr", i), 32'(out_instr), 32'(vecs[i].exp_instr));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'd1);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(exp_errs));
      tick();
      chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
    end

    // LLB/LHB pair with backpressure
    out_ready = 1'b0;
    send(2'b11, 16'h12AB, 16'hA300);
    chk("pair_w1_instr", 32'(out_instr), 32'hA3AB);
    chk("pair_w1_last", 32'(out_last), 32'd0);
    chk("pair_w1_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp%0d_instr", c), 32'(out_instr), 32'hA3AB);
      chk($sformatf("bp%0d_last", c), 32'(out_last), 32'd0);
      chk($sformatf("bp%0d_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("pair_w1_ready_or", 32'(in_ready), 32'd0);
    tick();
    chk("pair_w2_valid", 32'(out_valid), 32'd1);
    chk("pair_w2_instr", 32'(out_instr), 32'hB312);
    chk("pair_w2_last", 32'(out_last), 32'd1);
    chk("pair_w2_err", 32'(out_err), 32'd0);
    chk("pair_w2_ready", 32'(in_ready), 32'd1);
    tick();
    chk("pair_drain", 32'(out_valid), 32'd0);

    // Ten back-to-back single-word requests, one word per cycle
    in_kind = 2'b11;
    in_base = 16'h3400;
    for (int i = 0; i < 10; i++) begin
      in_value = 16'(i * 7);
      in_valid = 1'b1;
      #1;
      chk($sformatf("b2b%0d_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_instr", i), 32'(out_instr), 32'(16'h3400 + 16'(i * 7)));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset while a pair is pending
    out_ready = 1'b0;
    send(2'b11, 16'h5566, 16'hA300);
    chk("rstpair_w1", 32'(out_instr), 32'hA366);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstpair_valid", 32'(out_valid), 32'd0);
    chk("rstpair_instr", 32'(out_instr), 32'h0);
    chk("rstpair_errcnt", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rstpair_idle%0d", c), 32'(out_valid), 32'd0);
    end

    // Error counter saturation
    in_kind  = 2'b01;
    in_value = 16'h0008;
    in_base  = 16'h0000;
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("sat_255", 32'(err_count), 32'hFF);
    chk("sat_err_flag", 32'(out_err), 32'd1);
    tick();
    chk("sat_256", 32'(err_count), 32'hFF);
    tick();
    in_valid = 1'b0;
    chk("sat_257", 32'(err_count), 32'hFF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encode.md
# imm_encode

Immediate-field encoder for the 16-bit ISA: the inverse of decode-stage immediate extraction. Accepts a desired immediate value, an immediate kind and an instruction template. Emits the instruction word(s) whose immediate field reproduces that value when decoded. Sits in the program-loader/self-test path ahead of instruction-memory writes; expands unrepresentable zero-extended constants into an LLB/LHB pair and flags out-of-range values.

## Interface
- LHB_OPCODE, 4'b1011, opcode written into bits [15:12] of the second (high-byte) word of an LLB/LHB pair
- ERR_CNT_W, 8, width of the saturating error counter
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready at rising clk
- in_kind  input  2  00 branch (9-bit, <<1), 01 mem offset (4-bit), 10 imm (8-bit, <<1), 11 zero-ext byte / LLB-LHB
- in_value  input  16  target decoded value (two's complement for kinds 00/01/10)
- in_base  input  16  instruction template; non-field bits copied to output
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_instr  output  16  encoded word
- out_last  output  1  final word of current request
- out_err  output  1  value not representable; field bits forced to 0
- err_count  output  ERR_CNT_W  saturating count of accepted requests with error

## Operation
- Field encoding (non-field bits = in_base):
  - 00: legal iff value[0]==0 and -512 <= value <= 510; bits[8:0] = value[9:1]
  - 01: legal iff -8 <= value <= 7; bits[3:0] = value[3:0]
  - 10: legal iff value[0]==0 and -256 <= value <= 254; bits[7:0] = value[8:1]
  - 11: always legal; if value[15:8]==0 one word, bits[7:0]=value[7:0]; else two words: word1 = in_base with bits[7:0]=value[7:0]; word2 = {LHB_OPCODE, in_base[11:8], value[15:8]}
- Range test on full 16-bit signed in_value (sign-extension of field must equal in_value).
- Illegal: one word, field bits 0, out_err=1, out_last=1, err_count += 1 (saturates at all-ones).
- States: EMPTY (out_valid=0), ONE (output reg full, no pending), TWO (output reg full + pending second word).
- in_ready = (state==EMPTY) || (state==ONE && out_ready). Combinational, no dependence on in_valid.
- Accept: output reg <- word1; state -> TWO if two-word request, else ONE.
- ONE, out transfer, no accept -> EMPTY. ONE, out transfer and accept -> ONE/TWO per new request.
- TWO, out transfer -> output reg <- pending word2 (out_last=1, out_err=0), state ONE; no accept in TWO.
- Output reg and out_last/out_err held stable while out_valid && !out_ready.

## Timing
- Reset (async assert, synchronous-safe deassert at clk): state EMPTY, out_valid 0, out_instr 16'h0000, out_last 0, out_err 0, err_count 0; in_ready 1 after reset.
- Latency: accept at edge N -> out_valid=1 with word1 after edge N (visible cycle N+1).
- Throughput: one word per cycle; single-word requests back-to-back with out_ready=1; two-word request blocks input for one extra cycle.
- Reset mid-pair discards pending word2; no partial output after reset.
- err_count increments at accept edge of illegal request.

## Test plan
- kind 00, value 16'hFFFE, base 16'hC000 -> out_instr 16'hC1FF, out_last 1, out_err 0, one cycle after accept.
- kind 01, value 16'h0008, base 16'h8120 -> out_instr 16'h8120, out_err 1, err_count 1; value 16'hFFF8 -> 16'h8128, out_err 0.
- kind 10, value 16'h0101 -> out_err 1; value 16'hFF00 -> bits[7:0]=8'h80, out_err 0.
- kind 11, value 16'h12AB, base 16'hA300 -> 16'hA3AB (last 0) then 16'hB312 (last 1); in_ready 0 while TWO; value 16'h00AB -> single 16'hA3AB.
- Backpressure: out_ready 0 for 3 cycles during pair -> out_instr/out_last stable, in_ready 0; 10 back-to-back single requests at out_ready=1 -> 10 words in 10 cycles.
- Assert rst_n in TWO -> out_valid 0 immediately, word2 never emitted; 256 illegal requests -> err_count 8'hFF.
